// File: rtl/fc_rst_seq.sv
// Power-good / reset sequencer: releases lan_powergood_rst_b, waits for clk_stable
// under a timeout, then releases core_rst_b after a microsecond-scaled delay.
module fc_rst_seq #(
  parameter int CYC_PER_US = 100,
  parameter int PG_DLY_US  = 10,
  parameter int RST_DLY_US = 5,
  parameter int ACK_TO_US  = 1000,
  parameter int CNT_W      = 16
) (
  input  logic       tb_clk,
  input  logic       tb_rst_b,
  input  logic       start,
  input  logic       clk_stable,
  input  logic       dis_timers,
  output logic       lan_powergood_rst_b,
  output logic       core_rst_b,
  output logic       seq_done,
  output logic       timeout_err,
  output logic [2:0] state
);

  localparam int PS_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [PS_W-1:0]  PS_TC  = PS_W'(CYC_PER_US - 1);
  localparam logic [CNT_W-1:0] PG_LD  = CNT_W'(PG_DLY_US);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY_US);
  localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TO_US);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PG_WAIT  = 3'd1,
    CLK_WAIT = 3'd2,
    RST_WAIT = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [PS_W-1:0]  ps_cnt;
  logic [CNT_W-1:0] us_cnt;
  logic [CNT_W-1:0] load_val;
  logic             dis_lat;
  logic             us_tick;
  logic             expired;
  logic             entering;
  logic             in_delay;

  assign us_tick  = (ps_cnt == PS_TC);
  // A zero-length delay is loaded as 0 and expires after a single cycle.
  assign expired  = (us_cnt == '0) || ((us_cnt == ONE) && us_tick);
  assign entering = (nxt_state != cur_state);
  assign in_delay = (cur_state == PG_WAIT) || (cur_state == CLK_WAIT) ||
                    (cur_state == RST_WAIT);

  always_ff @(posedge tb_clk or negedge tb_rst_b) begin
    if (!tb_rst_b) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:     if (start) nxt_state = PG_WAIT;
      PG_WAIT:  if (expired) nxt_state = CLK_WAIT;
      CLK_WAIT: begin
        if (clk_stable) begin
          nxt_state = RST_WAIT;
        end else if (expired) begin
          nxt_state = ERR;
        end
      end
      // Losing the clock outranks finishing the delay.
      RST_WAIT: begin
        if (!clk_stable) begin
          nxt_state = CLK_WAIT;
        end else if (expired) begin
          nxt_state = DONE;
        end
      end
      DONE:     if (!clk_stable) nxt_state = CLK_WAIT;
      ERR:      nxt_state = ERR;
      default:  nxt_state = IDLE;
    endcase
    if (!start) begin
      nxt_state = IDLE;
    end
  end

  // PG_WAIT is only entered from IDLE, so the live dis_timers is the value being latched.
  always_comb begin
    load_val = '0;
    case (nxt_state)
      PG_WAIT:  load_val = dis_timers ? ONE : PG_LD;
      CLK_WAIT: load_val = ACK_LD;
      RST_WAIT: load_val = dis_lat ? ONE : RST_LD;
      default:  load_val = '0;
    endcase
  end

  always_ff @(posedge tb_clk or negedge tb_rst_b) begin
    if (!tb_rst_b) begin
      ps_cnt <= '0;
      us_cnt <= '0;
    end else if (entering) begin
      ps_cnt <= '0;
      us_cnt <= load_val;
    end else if (in_delay) begin
      ps_cnt <= us_tick ? '0 : ps_cnt + 1'b1;
      if (us_tick && (us_cnt != '0)) begin
        us_cnt <= us_cnt - 1'b1;
      end
    end else begin
      ps_cnt <= '0;
      us_cnt <= '0;
    end
  end

  always_ff @(posedge tb_clk or negedge tb_rst_b) begin
    if (!tb_rst_b) begin
      dis_lat <= 1'b0;
    end else if ((cur_state == IDLE) && start) begin
      dis_lat <= dis_timers;
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge tb_clk or negedge tb_rst_b) begin
    if (!tb_rst_b) begin
      lan_powergood_rst_b <= 1'b0;
      core_rst_b          <= 1'b0;
      seq_done            <= 1'b0;
      timeout_err         <= 1'b0;
    end else begin
      lan_powergood_rst_b <= (nxt_state == CLK_WAIT) || (nxt_state == RST_WAIT) ||
                             (nxt_state == DONE);
      core_rst_b          <= (nxt_state == DONE);
      seq_done            <= (nxt_state == DONE);
      timeout_err         <= (nxt_state == ERR);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_fc_rst_seq.sv
// Self-checking bench for fc_rst_seq: directed sequences plus randomized stimulus,
// compared cycle by cycle against a cycle-countdown reference model.
module tb_fc_rst_seq;

  localparam int CYC = 5;
  localparam int PG  = 4;
  localparam int RST = 3;
  localparam int ACK = 12;

  logic       tb_clk = 1'b0;
  logic       tb_rst_b;
  logic       start;
  logic       clk_stable;
  logic       dis_timers;
  logic       lan_powergood_rst_b;
  logic       core_rst_b;
  logic       seq_done;
  logic       timeout_err;
  logic [2:0] state;

  int tests_run;
  int tests_failed;
  int cyc;
  int lan_rise;
  int core_rise;
  bit prev_lan;
  bit prev_core;

  int m_state;
  int m_rem;
  bit m_dis;

  always #5 tb_clk = ~tb_clk;

  fc_rst_seq #(
    .CYC_PER_US(CYC),
    .PG_DLY_US (PG),
    .RST_DLY_US(RST),
    .ACK_TO_US (ACK),
    .CNT_W     (16)
  ) dut (
    .tb_clk             (tb_clk),
    .tb_rst_b           (tb_rst_b),
    .start              (start),
    .clk_stable         (clk_stable),
    .dis_timers         (dis_timers),
    .lan_powergood_rst_b(lan_powergood_rst_b),
    .core_rst_b         (core_rst_b),
    .seq_done           (seq_done),
    .timeout_err        (timeout_err),
    .state              (state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  function automatic int dwell(input int d);
    return (d == 0) ? 1 : d * CYC;
  endfunction

  // Reference model: each delay is a plain count of remaining cycles.
  function automatic void model_step();
    if (!tb_rst_b || !start) begin
      m_state = 0;
      m_rem   = 0;
    end else begin
      case (m_state)
        0: begin
          m_dis   = dis_timers;
          m_state = 1;
          m_rem   = dwell(dis_timers ? 1 : PG);
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_state = 2;
            m_rem   = dwell(ACK);
          end
        end
        2: begin
          if (clk_stable) begin
            m_state = 3;
            m_rem   = dwell(m_dis ? 1 : RST);
          end else begin
            m_rem--;
            if (m_rem == 0) m_state = 5;
          end
        end
        3: begin
          if (!clk_stable) begin
            m_state = 2;
            m_rem   = dwell(ACK);
          end else begin
            m_rem--;
            if (m_rem == 0) m_state = 4;
          end
        end
        4: begin
          if (!clk_stable) begin
            m_state = 2;
            m_rem   = dwell(ACK);
          end
        end
        default: m_state = m_state;
      endcase
    end
  endfunction

  function automatic logic [6:0] exp_outs();
    logic [2:0] s;
    s = m_state[2:0];
    return {s, (m_state >= 2 && m_state <= 4), (m_state == 4), (m_state == 4), (m_state == 5)};
  endfunction

  function automatic logic [6:0] act_outs();
    return {state, lan_powergood_rst_b, core_rst_b, seq_done, timeout_err};
  endfunction

  task automatic applyStimulus(input bit s, input bit cs, input bit dt, input int n);
    for (int i = 0; i < n; i++) begin
      start      = s;
      clk_stable = cs;
      dis_timers = dt;
      @(posedge tb_clk);
      model_step();
      cyc++;
      @(negedge tb_clk);
      checkOutput("outs", {25'b0, act_outs()}, {25'b0, exp_outs()});
      if (lan_powergood_rst_b && !prev_lan) lan_rise = cyc;
      if (core_rst_b && !prev_core) core_rise = cyc;
      prev_lan  = lan_powergood_rst_b;
      prev_core = core_rst_b;
    end
  endtask

  task automatic new_scenario();
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    cyc       = 0;
    lan_rise  = -1;
    core_rise = -1;
  endtask

  initial begin
    bit cs_r;
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    m_state      = 0;
    m_rem        = 0;
    m_dis        = 1'b0;
    prev_lan     = 1'b0;
    prev_core    = 1'b0;
    tb_rst_b     = 1'b0;
    start        = 1'b0;
    clk_stable   = 1'b0;
    dis_timers   = 1'b0;
    #3;
    checkOutput("reset_outs", {25'b0, act_outs()}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    tb_rst_b = 1'b1;

    // Full default-style bring-up with clk_stable already high
    new_scenario();
    applyStimulus(1'b1, 1'b1, 1'b0, PG*CYC + RST*CYC + 5);
    checkOutput("s1_lan_rise", lan_rise, PG*CYC + 1);
    checkOutput("s1_core_rise", core_rise, PG*CYC + RST*CYC + 2);
    checkOutput("s1_state", state, 4);

    // Late clk_stable
    new_scenario();
    applyStimulus(1'b1, 1'b0, 1'b0, PG*CYC + 8);
    applyStimulus(1'b1, 1'b1, 1'b0, RST*CYC + 3);
    checkOutput("s2_lan_rise", lan_rise, PG*CYC + 1);
    checkOutput("s2_core_rise", core_rise, PG*CYC + 9 + RST*CYC);

    // Timeout into ERR, sticky until start drops
    new_scenario();
    applyStimulus(1'b1, 1'b0, 1'b0, PG*CYC + ACK*CYC);
    checkOutput("s3_pre_timeout", state, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("s3_err_state", state, 5);
    checkOutput("s3_err_flag", {timeout_err, lan_powergood_rst_b, core_rst_b}, 3'b100);
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    checkOutput("s3_err_sticky", state, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("s3_exit", {state, timeout_err}, 4'b0000);

    // dis_timers latched at acceptance; later toggles ignored
    new_scenario();
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 2*CYC + 4; i++) applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1);
    checkOutput("s4_lan_rise", lan_rise, CYC + 1);
    checkOutput("s4_core_rise", core_rise, 2*CYC + 2);

    // clk_stable drop in DONE; the latched short delay still applies
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("s5_drop", {state, lan_powergood_rst_b, core_rst_b}, {3'd2, 2'b10});
    cyc       = 0;
    core_rise = -1;
    applyStimulus(1'b1, 1'b1, 1'b0, CYC + 3);
    checkOutput("s5_rerelease", core_rise, CYC + 1);

    // Abort during PG_WAIT
    new_scenario();
    applyStimulus(1'b1, 1'b1, 1'b0, PG*CYC/2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("s6_abort_idle", state, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, PG*CYC);
    checkOutput("s6_no_release", lan_rise, 32'hffffffff);

    // Asynchronous reset in RST_WAIT, observed before the next clock edge
    new_scenario();
    applyStimulus(1'b1, 1'b1, 1'b0, PG*CYC + 3);
    checkOutput("s6_in_rst_wait", state, 3);
    #2 tb_rst_b = 1'b0;
    m_state = 0;
    m_rem   = 0;
    #1;
    checkOutput("s6_async_rst", {25'b0, act_outs()}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    tb_rst_b = 1'b1;

    // Ack arrives in the timeout expiry cycle
    new_scenario();
    applyStimulus(1'b1, 1'b0, 1'b0, PG*CYC + ACK*CYC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("s6_ack_wins", {state, timeout_err}, {3'd3, 1'b0});

    // Randomized traffic against the model
    new_scenario();
    cs_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) cs_r = ~cs_r;
      applyStimulus(($urandom_range(0, 99) != 0), cs_r, 1'($urandom_range(0, 1)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
